// File: rtl/ex_hazard_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// ex_hazard_ctrl_pkg : shared types and constants for the EX hazard controller
// Revision: 1.0
//------------------------------------------------------------------------------
package ex_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LD_STALL  = 2'd1,
    ST_BR_SHADOW = 2'd2
  } state_t;

  localparam logic [4:0] XZR     = 5'd31;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // XZR is hard-wired zero, so it never aliases a real producer.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (dst != XZR) && (src == dst);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
//------------------------------------------------------------------------------
// fwd_select : picks the newest in-flight producer of one source register
// Revision: 1.0
//------------------------------------------------------------------------------
module fwd_select
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_we,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_we,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_ex_we && reg_match(i_src, i_ex_rd)) begin
      o_sel = FWD_EX;
    end else if (i_mem_we && reg_match(i_src, i_mem_rd)) begin
      o_sel = FWD_MEM;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// ex_hazard_ctrl : load-use stall, branch flush and operand forwarding control
// Revision: 1.0
//------------------------------------------------------------------------------
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        IdValid,
  input  logic [4:0]  IdRn,
  input  logic [4:0]  IdRm,
  input  logic        IdUsesRn,
  input  logic        IdUsesRm,
  input  logic        IdUsesFlags,
  input  logic [4:0]  ExRd,
  input  logic        ExRegWrite,
  input  logic        ExMemRead,
  input  logic        ExFlagE,
  input  logic        BrTaken,
  input  logic [4:0]  MemRd,
  input  logic        MemRegWrite,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        BubbleE,
  output logic [1:0]  FwdA,
  output logic [1:0]  FwdB,
  output logic        FwdFlag,
  output logic [15:0] StallCnt
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_stall_cnt;
  logic        w_load_use;
  logic [1:0]  w_sel_a;
  logic [1:0]  w_sel_b;

  fwd_select u_fwd_a (
    .i_src    (IdRn),
    .i_ex_rd  (ExRd),
    .i_ex_we  (ExRegWrite),
    .i_mem_rd (MemRd),
    .i_mem_we (MemRegWrite),
    .o_sel    (w_sel_a)
  );

  fwd_select u_fwd_b (
    .i_src    (IdRm),
    .i_ex_rd  (ExRd),
    .i_ex_we  (ExRegWrite),
    .i_mem_rd (MemRd),
    .i_mem_we (MemRegWrite),
    .o_sel    (w_sel_b)
  );

  assign w_load_use = IdValid && ExMemRead &&
                      ((IdUsesRn && reg_match(IdRn, ExRd)) ||
                       (IdUsesRm && reg_match(IdRm, ExRd)));

  always_comb begin
    w_next  = r_state;
    StallF  = 1'b0;
    StallD  = 1'b0;
    FlushD  = 1'b0;
    BubbleE = 1'b0;
    case (r_state)
      ST_BR_SHADOW: begin
        FlushD  = 1'b1;
        BubbleE = 1'b1;
        w_next  = ST_RUN;
      end
      ST_RUN, ST_LD_STALL: begin
        w_next = ST_RUN;
        if (BrTaken) begin
          FlushD  = 1'b1;
          BubbleE = 1'b1;
          w_next  = ST_BR_SHADOW;
        end else if (r_state == ST_RUN && w_load_use) begin
          // The already-stalled instruction must not re-stall on the same pair.
          StallF  = 1'b1;
          StallD  = 1'b1;
          BubbleE = 1'b1;
          w_next  = ST_LD_STALL;
        end
      end
      default: w_next = ST_RUN;
    endcase
    if (reset) begin
      StallF  = 1'b0;
      StallD  = 1'b0;
      FlushD  = 1'b0;
      BubbleE = 1'b0;
      w_next  = ST_RUN;
    end
  end

  assign FwdA     = (BubbleE || reset) ? FWD_RF : w_sel_a;
  assign FwdB     = (BubbleE || reset) ? FWD_RF : w_sel_b;
  assign FwdFlag  = !(BubbleE || reset) && IdUsesFlags && ExFlagE;
  assign StallCnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      if (StallF && r_stall_cnt != 16'hFFFF) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_ex_hazard_ctrl : reference-model bench for the EX hazard controller
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        IdValid, IdUsesRn, IdUsesRm, IdUsesFlags;
  logic [4:0]  IdRn, IdRm, ExRd, MemRd;
  logic        ExRegWrite, ExMemRead, ExFlagE, BrTaken, MemRegWrite;
  logic        StallF, StallD, FlushD, BubbleE, FwdFlag;
  logic [1:0]  FwdA, FwdB;
  logic [15:0] StallCnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference history: was last cycle a taken branch / a load-use stall.
  logic m_prev_br    = 1'b0;
  logic m_prev_stall = 1'b0;
  int   m_cnt        = 0;
  logic cmp_en       = 1'b0;

  always #5 clk = ~clk;

  ex_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .IdValid(IdValid), .IdRn(IdRn), .IdRm(IdRm), .IdUsesRn(IdUsesRn),
    .IdUsesRm(IdUsesRm), .IdUsesFlags(IdUsesFlags),
    .ExRd(ExRd), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExFlagE(ExFlagE), .BrTaken(BrTaken),
    .MemRd(MemRd), .MemRegWrite(MemRegWrite),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .BubbleE(BubbleE),
    .FwdA(FwdA), .FwdB(FwdB), .FwdFlag(FwdFlag), .StallCnt(StallCnt)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_load_use();
    return IdValid && ExMemRead && ExRd != 5'd31 &&
           ((IdUsesRn && IdRn == ExRd) || (IdUsesRm && IdRm == ExRd));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (ExRegWrite && ExRd != 5'd31 && src == ExRd) return 2'b01;
    if (MemRegWrite && MemRd != 5'd31 && src == MemRd) return 2'b10;
    return 2'b00;
  endfunction

  // Expected outputs for the current cycle from the history bits and inputs.
  logic e_stall, e_flush, e_bubble;
  always_comb begin
    e_stall  = 1'b0;
    e_flush  = 1'b0;
    e_bubble = 1'b0;
    if (!reset) begin
      if (m_prev_br || BrTaken) begin
        e_flush  = 1'b1;
        e_bubble = 1'b1;
      end else if (m_load_use() && !m_prev_stall) begin
        e_stall  = 1'b1;
        e_bubble = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_prev_br    <= 1'b0;
      m_prev_stall <= 1'b0;
      m_cnt        <= 0;
    end else begin
      m_prev_br    <= !m_prev_br && BrTaken;
      m_prev_stall <= e_stall;
      if (e_stall) m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic quiet;
      quiet = reset || e_bubble;
      check("StallF",  {15'd0, StallF},  {15'd0, e_stall});
      check("StallD",  {15'd0, StallD},  {15'd0, e_stall});
      check("FlushD",  {15'd0, FlushD},  {15'd0, e_flush});
      check("BubbleE", {15'd0, BubbleE}, {15'd0, e_bubble});
      check("FwdA",    {14'd0, FwdA},    quiet ? 16'd0 : {14'd0, m_fwd(IdRn)});
      check("FwdB",    {14'd0, FwdB},    quiet ? 16'd0 : {14'd0, m_fwd(IdRm)});
      check("FwdFlag", {15'd0, FwdFlag}, {15'd0, !quiet && IdUsesFlags && ExFlagE});
      check("StallCnt", StallCnt, m_cnt[15:0]);
    end
  end

  task automatic idle();
    reset = 0; IdValid = 0; IdRn = 0; IdRm = 0; IdUsesRn = 0; IdUsesRm = 0;
    IdUsesFlags = 0; ExRd = 0; ExRegWrite = 0; ExMemRead = 0; ExFlagE = 0;
    BrTaken = 0; MemRd = 0; MemRegWrite = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_rn(input logic [4:0] r);
    idle();
    IdValid = 1; IdUsesRn = 1; IdRn = r; ExMemRead = 1; ExRd = r; ExRegWrite = 1;
  endtask

  task automatic do_reset();
    idle(); reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    cmp_en = 1'b1;
    step();
    @(negedge clk);
    check("rst_StallF", {15'd0, StallF}, 16'd0);
    check("rst_FlushD", {15'd0, FlushD}, 16'd0);
    check("rst_Cnt", StallCnt, 16'd0);

    // Load-use: one bubble, then released, count of one.
    step(); load_use_rn(5'd3);
    @(negedge clk);
    check("lu_StallF", {15'd0, StallF}, 16'd1);
    check("lu_BubbleE", {15'd0, BubbleE}, 16'd1);
    step();
    @(negedge clk);
    check("lu2_StallF", {15'd0, StallF}, 16'd0);
    check("lu2_BubbleE", {15'd0, BubbleE}, 16'd0);
    check("lu2_Cnt", StallCnt, 16'd1);

    // Forward priority on B.
    step(); idle();
    ExRd = 5; MemRd = 5; ExRegWrite = 1; MemRegWrite = 1; IdRm = 5; IdUsesRm = 1; IdValid = 1;
    @(negedge clk);
    check("fwd_ex", {14'd0, FwdB}, 16'd1);
    step(); ExRegWrite = 0;
    @(negedge clk);
    check("fwd_mem", {14'd0, FwdB}, 16'd2);

    // XZR never matches.
    step(); load_use_rn(5'd31);
    @(negedge clk);
    check("xzr_StallF", {15'd0, StallF}, 16'd0);
    check("xzr_FwdA", {14'd0, FwdA}, 16'd0);

    // Branch with load-use in the same cycle.
    step(); do_reset();
    load_use_rn(5'd4); BrTaken = 1;
    @(negedge clk);
    check("br_FlushD", {15'd0, FlushD}, 16'd1);
    check("br_StallF", {15'd0, StallF}, 16'd0);
    step();
    @(negedge clk);
    check("sh_FlushD", {15'd0, FlushD}, 16'd1);
    check("sh_BubbleE", {15'd0, BubbleE}, 16'd1);
    check("sh_StallF", {15'd0, StallF}, 16'd0);
    step(); idle();
    @(negedge clk);
    check("br3_FlushD", {15'd0, FlushD}, 16'd0);
    check("br3_Cnt", StallCnt, 16'd0);

    // Reset aborts a branch shadow.
    step(); BrTaken = 1;
    step(); idle(); reset = 1;
    @(negedge clk);
    check("rmid_FlushD", {15'd0, FlushD}, 16'd0);
    step(); reset = 0;
    @(negedge clk);
    check("rpost_FlushD", {15'd0, FlushD}, 16'd0);
    check("rpost_BubbleE", {15'd0, BubbleE}, 16'd0);
    check("rpost_Cnt", StallCnt, 16'd0);

    // Saturation: two real stalls, then jump the counter near the top.
    for (int i = 0; i < 2; i++) begin
      step(); load_use_rn(5'd7);
      step(); idle();
    end
    @(negedge clk);
    check("sat_pre", StallCnt, 16'd2);
    @(posedge clk);
    #2;
    force dut.r_stall_cnt = 16'hFFFE;
    m_cnt = 65534;
    #1;
    release dut.r_stall_cnt;
    for (int i = 0; i < 3; i++) begin
      step(); load_use_rn(5'd9);
      step(); idle();
    end
    @(negedge clk);
    check("sat_hold", StallCnt, 16'hFFFF);

    // Randomized traffic with a narrow register range to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      step();
      reset       = ($urandom_range(0, 39) == 0);
      IdValid     = ($urandom_range(0, 5) != 0);
      IdRn        = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      IdRm        = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      IdUsesRn    = 1'($urandom_range(0, 1));
      IdUsesRm    = 1'($urandom_range(0, 1));
      IdUsesFlags = 1'($urandom_range(0, 1));
      ExRd        = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      ExRegWrite  = 1'($urandom_range(0, 1));
      ExMemRead   = ($urandom_range(0, 2) == 0);
      ExFlagE     = 1'($urandom_range(0, 1));
      BrTaken     = ($urandom_range(0, 5) == 0);
      MemRd       = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      MemRegWrite = 1'($urandom_range(0, 1));
    end
    step(); idle();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have inputs IdValid (1), IdRn (5), IdRm (5), IdUsesRn (1), IdUsesRm (1), IdUsesFlags (1): decode-stage instruction and source-operand info.
REQ-004 SHALL have inputs ExRd (5), ExRegWrite (1), ExMemRead (1), ExFlagE (1), BrTaken (1): execute-stage instruction info; BrTaken means a taken branch resolved in EX.
REQ-005 SHALL have inputs MemRd (5), MemRegWrite (1): memory-stage destination info.
REQ-006 SHALL have outputs StallF (1), StallD (1): hold PC and the IF/ID register.
REQ-007 SHALL have outputs FlushD (1), BubbleE (1): clear IF/ID; force all-zero control into the execute control queue.
REQ-008 SHALL have outputs FwdA (2), FwdB (2), FwdFlag (1): forwarding selects, captured by the execute control queue.
REQ-009 SHALL have output StallCnt (16): saturating performance count of stall cycles.

Function
REQ-010 SHALL implement a 3-state FSM: RUN, LD_STALL, BR_SHADOW.
REQ-011 Register 31 (XZR) SHALL never match; any compare against 5'd31 is false.
REQ-012 LoadUse SHALL be IdValid & ExMemRead & ExRd != 31 & ((IdUsesRn & IdRn == ExRd) | (IdUsesRm & IdRm == ExRd)).
REQ-013 In RUN with BrTaken=1: FlushD=1, BubbleE=1, StallF=StallD=0 in that cycle; next state BR_SHADOW.
REQ-014 In BR_SHADOW: FlushD=1, BubbleE=1 for exactly one cycle; next state RUN regardless of inputs.
REQ-015 In RUN with BrTaken=0 and LoadUse=1: StallF=StallD=BubbleE=1 in that cycle; next state LD_STALL.
REQ-016 In LD_STALL: all stall, flush and bubble outputs 0; next state RUN. This SHALL give exactly one bubble per load-use pair.
REQ-017 BrTaken SHALL take priority over LoadUse in the same cycle; a load-use seen on a squashed path SHALL cause no stall.
REQ-018 BrTaken asserted in LD_STALL SHALL behave as in RUN (REQ-013). BrTaken asserted in BR_SHADOW SHALL be ignored.
REQ-019 FwdA SHALL be:
- 2'b01 if ExRegWrite & ExRd != 31 & IdRn == ExRd;
- else 2'b10 if MemRegWrite & MemRd != 31 & IdRn == MemRd;
- else 2'b00.
FwdB SHALL be identical using IdRm. Both are combinational and the EX match has priority.
REQ-020 FwdFlag SHALL be IdUsesFlags & ExFlagE (combinational).
REQ-021 When BubbleE=1, FwdA, FwdB and FwdFlag SHALL be driven 0.
REQ-022 StallCnt SHALL increment by 1 on each posedge where StallF=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-023 All stall, flush and bubble outputs SHALL be combinational functions of the registered state and the current inputs; the only registered values are the state and StallCnt.

Reset
REQ-024 A posedge with reset=1 SHALL set state to RUN and StallCnt to 0, overriding every other input including BrTaken.
REQ-025 During a reset cycle, StallF, StallD, FlushD, BubbleE, FwdA, FwdB and FwdFlag SHALL all be 0.
REQ-026 Reset asserted in LD_STALL or BR_SHADOW SHALL abort that sequence; no residual flush or bubble SHALL follow.

Structure
REQ-027 A shared package SHALL hold: the state enum (RUN, LD_STALL, BR_SHADOW), the XZR constant 5'd31, and the FWD_RF/FWD_EX/FWD_MEM encodings 2'b00/2'b01/2'b10.
REQ-028 There SHALL be one sub-module, fwd_select (5-bit source, EX/MEM destination and write-enable compare producing a 2-bit select), instantiated twice for A and B.

Verification
REQ-029 Load-use: ExMemRead=1, ExRd=3, IdRn=3, IdUsesRn=1 -> StallF/StallD/BubbleE=1 for one cycle, 0 next cycle; StallCnt=1.
REQ-030 Forward priority: ExRd=MemRd=5, both RegWrite=1, IdRm=5, IdUsesRm=1 -> FwdB=01; ExRegWrite=0 -> FwdB=10.
REQ-031 XZR: ExRd=31, ExMemRead=1, IdRn=31 -> no stall, FwdA=00.
REQ-032 Branch plus load-use in the same cycle: BrTaken=1 with a LoadUse condition -> FlushD/BubbleE=1 for 2 cycles, StallF=0 throughout, StallCnt unchanged.
REQ-033 Reset mid-sequence: BrTaken=1, then reset=1 on the next cycle -> FlushD=0 after that posedge, state RUN, StallCnt=0.
REQ-034 Saturation: StallCnt preloaded to 16'hFFFE by repeated stalls, then 3 more stalls -> StallCnt holds 16'hFFFF.
